// File: rtl/ov7670_capture.sv
// OV7670 parallel-bus capture: oversamples PCLK/VSYNC/HREF/D in the clk
// domain, pairs RGB565 bytes, converts to RGB444 and emits a frame-buffer
// write stream (addr/dout/we) plus frame_done and a sticky overrun flag.
// Optional build macro OV7670_CAPTURE_DECIMATE_EN enables 2x2 decimation.
module ov7670_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              config_finished,
    input  logic              cam_pclk,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    output logic [ADDR_W-1:0] addr,
    output logic [11:0]       dout,
    output logic              we,
    output logic              frame_done,
    output logic              overrun
);

    typedef enum logic [1:0] {
        WAIT_CFG   = 2'd0,
        WAIT_FRAME = 2'd1,
        ACTIVE     = 2'd2
    } state_t;

`ifdef OV7670_CAPTURE_DECIMATE_EN
    localparam logic [ADDR_W-1:0] H_LIM  = ADDR_W'(H_ACTIVE);
    localparam logic [ADDR_W-1:0] HALF_H = ADDR_W'(H_ACTIVE / 2);
    localparam logic [ADDR_W-1:0] HALF_V = ADDR_W'(V_ACTIVE / 2);
    logic [ADDR_W-1:0] x_q, x_d, y_q, y_d;
`else
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
    logic full_q, full_d;
`endif

    // Bit 0/1 form the two-flop synchronizer; bit 2 is the edge-detect copy.
    logic [2:0] pclk_q, pclk_d, vsync_q, vsync_d, href_q, href_d;
    logic [7:0] data1_q, data1_d, data2_q, data2_d;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [11:0]       dout_q, dout_d;
    logic              we_q, we_d, frame_done_q, frame_done_d;
    logic              overrun_q, overrun_d, phase_q, phase_d;
    logic [6:0]        hi_q, hi_d;   // {R[4:1], G[5:3]} of the first byte

    logic sample_s, vs_fall_s, vs_rise_s, href_fall_s;

    assign sample_s    = pclk_q[1] & ~pclk_q[2];
    assign vs_fall_s   = ~vsync_q[1] & vsync_q[2];
    assign vs_rise_s   = vsync_q[1] & ~vsync_q[2];
    assign href_fall_s = ~href_q[1] & href_q[2];

    // Synchronizer shift: all bus signals advance on the same clk edges.
    always_comb begin
        pclk_d  = {pclk_q[1:0], cam_pclk};
        vsync_d = {vsync_q[1:0], cam_vsync};
        href_d  = {href_q[1:0], cam_href};
        data1_d = cam_data;
        data2_d = data1_q;
    end

    // Capture FSM, byte pairing, pixel write generation and address update.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        dout_d       = dout_q;
        we_d         = 1'b0;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;
        phase_d      = phase_q;
        hi_d         = hi_q;
`ifdef OV7670_CAPTURE_DECIMATE_EN
        x_d = x_q;
        y_d = y_q;
`else
        full_d = full_q;
        // Advance the address the cycle after a write; park on the last slot.
        if (we_q) begin
            if (addr_q == LAST_ADDR) begin
                full_d = 1'b1;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end else begin
            addr_d = addr_q;
        end
`endif
        case (state_q)
            WAIT_CFG: begin
                if (config_finished) begin
                    state_d = WAIT_FRAME;
                end else begin
                    state_d = WAIT_CFG;
                end
            end
            WAIT_FRAME: begin
                if (vs_fall_s) begin
                    state_d = ACTIVE;
                    addr_d  = '0;
                    phase_d = 1'b0;
`ifdef OV7670_CAPTURE_DECIMATE_EN
                    x_d = '0;
                    y_d = '0;
`else
                    full_d = 1'b0;
`endif
                end else begin
                    state_d = WAIT_FRAME;
                end
            end
            ACTIVE: begin
                if (sample_s && href_q[1]) begin
                    if (!phase_q) begin
                        hi_d    = {data2_q[7:4], data2_q[2:0]};
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
`ifdef OV7670_CAPTURE_DECIMATE_EN
                        x_d = x_q + ADDR_W'(1);
                        if ((x_q < H_LIM) && !x_q[0] && !y_q[0]) begin
                            if ((y_q >> 1) >= HALF_V) begin
                                overrun_d = 1'b1;
                            end else begin
                                we_d   = 1'b1;
                                dout_d = {hi_q, data2_q[7], data2_q[4:1]};
                                addr_d = ((y_q >> 1) * HALF_H) + (x_q >> 1);
                            end
                        end else begin
                            we_d = 1'b0;
                        end
`else
                        if (full_q) begin
                            overrun_d = 1'b1;
                        end else begin
                            we_d   = 1'b1;
                            dout_d = {hi_q, data2_q[7], data2_q[4:1]};
                        end
`endif
                    end
                end else begin
                    phase_d = phase_q;
                end
                // Line end: a lone odd byte is simply forgotten.
                if (href_fall_s) begin
                    phase_d = 1'b0;
`ifdef OV7670_CAPTURE_DECIMATE_EN
                    x_d = '0;
                    y_d = y_q + ADDR_W'(1);
`endif
                end else begin
                    hi_d = hi_d;
                end
                if (vs_rise_s) begin
                    frame_done_d = 1'b1;
                    state_d      = WAIT_FRAME;
                end else begin
                    frame_done_d = 1'b0;
                end
            end
            default: begin
                state_d = WAIT_CFG;
            end
        endcase
        // Losing configuration aborts capture immediately.
        if (!config_finished) begin
            state_d = WAIT_CFG;
            we_d    = 1'b0;
        end else begin
            we_d = we_d;
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pclk_q       <= '0;
            vsync_q      <= '0;
            href_q       <= '0;
            data1_q      <= '0;
            data2_q      <= '0;
            state_q      <= WAIT_CFG;
            addr_q       <= '0;
            dout_q       <= '0;
            we_q         <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            phase_q      <= 1'b0;
            hi_q         <= '0;
`ifdef OV7670_CAPTURE_DECIMATE_EN
            x_q <= '0;
            y_q <= '0;
`else
            full_q <= 1'b0;
`endif
        end else begin
            pclk_q       <= pclk_d;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            data1_q      <= data1_d;
            data2_q      <= data2_d;
            state_q      <= state_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
            we_q         <= we_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            phase_q      <= phase_d;
            hi_q         <= hi_d;
`ifdef OV7670_CAPTURE_DECIMATE_EN
            x_q <= x_d;
            y_q <= y_d;
`else
            full_q <= full_d;
`endif
        end
    end

    assign addr       = addr_q;
    assign dout       = dout_q;
    assign we         = we_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed testbench for ov7670_capture on a 4x2 frame.
module tb_ov7670_capture;

    typedef logic [7:0] byte_arr_t [0:15];

    logic        clk = 1'b0;
    logic        rst, config_finished, cam_pclk, cam_vsync, cam_href;
    logic [7:0]  cam_data;
    logic [18:0] addr;
    logic [11:0] dout;
    logic        we, frame_done, overrun;

    int checks = 0;
    int errors = 0;
    int n_wr = 0;
    int fd_cycles = 0;
    logic [31:0] wa [0:31];
    logic [31:0] wd [0:31];
    byte_arr_t line_a, line_b, line_c;

    always #5 clk = ~clk;

    ov7670_capture #(.H_ACTIVE(4), .V_ACTIVE(2), .ADDR_W(19)) dut (
        .clk(clk), .rst(rst), .config_finished(config_finished),
        .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .addr(addr), .dout(dout), .we(we),
        .frame_done(frame_done), .overrun(overrun)
    );

    // Log every write strobe and count frame_done cycles.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (n_wr < 32) begin
                wa[n_wr] <= 32'(addr);
                wd[n_wr] <= 32'(dout);
            end
            n_wr <= n_wr + 1;
        end
        if (frame_done === 1'b1) fd_cycles <= fd_cycles + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        tick(1);
        n_wr = 0;
        fd_cycles = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        cam_data = b;
        tick(3);
        cam_pclk = 1'b1;
        tick(4);
        cam_pclk = 1'b0;
        tick(1);
    endtask

    task automatic send_line(input byte_arr_t bytes, input int nb);
        cam_href = 1'b1;
        tick(2);
        for (int i = 0; i < nb; i++) send_byte(bytes[i]);
        cam_href = 1'b0;
        tick(4);
    endtask

    task automatic frame_start();
        cam_vsync = 1'b1;
        tick(4);
        cam_vsync = 1'b0;
        tick(4);
    endtask

    task automatic frame_end();
        cam_vsync = 1'b1;
        tick(6);
    endtask

    initial begin
        rst = 1'b1; config_finished = 1'b0; cam_pclk = 1'b0;
        cam_vsync = 1'b1; cam_href = 1'b0; cam_data = 8'h00;
        line_a = '{0:8'hF8, 1:8'h1F, 2:8'h07, 3:8'hE0, 4:8'h12, 5:8'h34,
                   6:8'hAB, 7:8'hCD, 8:8'h77, default:8'h00};
        line_b = '{0:8'h00, 1:8'h00, 2:8'hFF, 3:8'hFF, 4:8'h5A, 5:8'hA5,
                   6:8'hC3, 7:8'h3C, default:8'h00};
        line_c = '{0:8'h11, 1:8'h22, default:8'h00};
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_addr", 32'(addr), 32'd0);
        check_eq("rst_dout", 32'(dout), 32'd0);
        check_eq("rst_we", 32'(we), 32'd0);
        check_eq("rst_frame_done", 32'(frame_done), 32'd0);
        check_eq("rst_overrun", 32'(overrun), 32'd0);

        // Bus activity while unconfigured must be ignored.
        clear_log();
        frame_start();
        send_line(line_a, 8);
        frame_end();
        check_eq("cfg_gate_writes", 32'(n_wr), 32'd0);
        check_eq("cfg_gate_addr", 32'(addr), 32'd0);
        config_finished = 1'b1;
        tick(2);

`ifdef OV7670_CAPTURE_DECIMATE_EN
        clear_log();
        frame_start();
        send_line(line_a, 8);
        send_line(line_b, 8);
        frame_end();
        check_eq("dec_writes", 32'(n_wr), 32'd2);
        check_eq("dec_addr0", wa[0], 32'd0);
        check_eq("dec_dout0", wd[0], 32'hF0F);
        check_eq("dec_addr1", wa[1], 32'd1);
        check_eq("dec_dout1", wd[1], 32'h14A);
        check_eq("dec_frame_done", 32'(fd_cycles), 32'd1);
        check_eq("dec_overrun", 32'(overrun), 32'd0);
        clear_log();
        frame_start();
        send_line(line_a, 4);
        frame_end();
        check_eq("dec_f2_writes", 32'(n_wr), 32'd1);
        check_eq("dec_f2_addr0", wa[0], 32'd0);
`else
        // Frame A: full 4x2 frame.
        clear_log();
        frame_start();
        send_line(line_a, 8);
        send_line(line_b, 8);
        frame_end();
        check_eq("fa_writes", 32'(n_wr), 32'd8);
        for (int i = 0; i < 8; i++) check_eq($sformatf("fa_addr%0d", i), wa[i], 32'(i));
        check_eq("fa_dout0", wd[0], 32'hF0F);
        check_eq("fa_dout1", wd[1], 32'h0F0);
        check_eq("fa_dout2", wd[2], 32'h14A);
        check_eq("fa_dout3", wd[3], 32'hA76);
        check_eq("fa_dout4", wd[4], 32'h000);
        check_eq("fa_dout5", wd[5], 32'hFFF);
        check_eq("fa_dout6", wd[6], 32'h552);
        check_eq("fa_dout7", wd[7], 32'hC6E);
        check_eq("fa_frame_done", 32'(fd_cycles), 32'd1);
        check_eq("fa_addr_held", 32'(addr), 32'd7);
        check_eq("fa_overrun", 32'(overrun), 32'd0);

        // Frame B: 9-byte line, full line, then one pixel too many.
        clear_log();
        frame_start();
        send_line(line_a, 9);
        send_line(line_b, 8);
        send_line(line_c, 2);
        frame_end();
        check_eq("fb_writes", 32'(n_wr), 32'd8);
        check_eq("fb_restart_addr", wa[0], 32'd0);
        check_eq("fb_odd_drop_addr", wa[4], 32'd4);
        check_eq("fb_odd_drop_dout", wd[4], 32'h000);
        check_eq("fb_last_addr", wa[7], 32'd7);
        check_eq("fb_addr_held", 32'(addr), 32'd7);
        check_eq("fb_overrun", 32'(overrun), 32'd1);

        // Frame C: reset after three pixels.
        clear_log();
        frame_start();
        cam_href = 1'b1;
        tick(2);
        for (int i = 0; i < 6; i++) send_byte(line_a[i]);
        tick(3);
        check_eq("fc_pre_rst_writes", 32'(n_wr), 32'd3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check_eq("fc_rst_addr", 32'(addr), 32'd0);
        check_eq("fc_rst_dout", 32'(dout), 32'd0);
        check_eq("fc_rst_we", 32'(we), 32'd0);
        check_eq("fc_rst_overrun", 32'(overrun), 32'd0);
        for (int i = 0; i < 4; i++) send_byte(line_b[i]);
        cam_href = 1'b0;
        tick(4);
        frame_end();
        check_eq("fc_post_rst_writes", 32'(n_wr), 32'd3);
        check_eq("fc_frame_done", 32'(fd_cycles), 32'd0);

        // Frame D: capture resumes, then config drops at a pixel completion.
        clear_log();
        frame_start();
        cam_href = 1'b1;
        tick(2);
        send_byte(8'hF8);
        send_byte(8'h1F);
        send_byte(8'h07);
        cam_data = 8'hE0;
        tick(3);
        cam_pclk = 1'b1;
        tick(2);
        config_finished = 1'b0;
        tick(1);
        @(negedge clk);
        check_eq("fd_cfg_drop_we", 32'(we), 32'd0);
        tick(2);
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        tick(4);
        check_eq("fd_writes", 32'(n_wr), 32'd1);
        check_eq("fd_addr0", wa[0], 32'd0);
        check_eq("fd_dout0", wd[0], 32'hF0F);
`endif
        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
